// File: rtl/paddle_scan_ctrl.sv
// Once per frame, measures both 555 paddle timers over one shared tick counter.
// Define PADDLE_AVG_EN to publish the average of the previous and new position.
module paddle_scan_ctrl #(
  parameter int CLKS_PER_TICK = 250,
  parameter int TRIG_CLKS     = 25,
  parameter int POS_W         = 8,
  parameter int MAX_TICKS     = 240
) (
  input  logic             i_Clk,
  input  logic             i_Rst_N,
  input  logic             i_VReset,
  input  logic [1:0]       i_555_Output,
  output logic [1:0]       o_555_Trigger,
  output logic [POS_W-1:0] o_Pos0,
  output logic [POS_W-1:0] o_Pos1,
  output logic [1:0]       o_Timeout,
  output logic             o_Valid,
  output logic             o_Busy
);

  localparam int PSC_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TRG_W = (TRIG_CLKS > 1) ? $clog2(TRIG_CLKS) : 1;

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLKS_PER_TICK - 1);
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CLKS - 1);
  localparam logic [TRG_W-1:0] TRG_ONE  = TRG_W'(1);
  localparam logic [POS_W-1:0] CNT_MAX  = POS_W'(MAX_TICKS);
  localparam logic [POS_W-1:0] CNT_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRIG    = 2'd1,
    S_MEASURE = 2'd2,
    S_LATCH   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic             r_sel;
  logic [TRG_W-1:0] r_trg;
  logic [PSC_W-1:0] r_psc;
  logic             r_tick;
  logic [POS_W-1:0] r_cnt;
  logic             r_to;
  logic [POS_W-1:0] r_pos0;
  logic [POS_W-1:0] r_pos1;
  logic [1:0]       r_timeout;

  logic             w_in;
  logic [1:0]       w_trigger;
  logic             w_valid;
  logic [POS_W-1:0] w_new_pos;

  assign w_in = r_sync[r_sel];

`ifdef PADDLE_AVG_EN
  logic [POS_W-1:0] w_old_pos;
  logic [POS_W:0]   w_sum;
  assign w_old_pos = r_sel ? r_pos1 : r_pos0;
  assign w_sum     = {1'b0, w_old_pos} + {1'b0, r_cnt};
  assign w_new_pos = w_sum[POS_W:1];
`else
  assign w_new_pos = r_cnt;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= i_555_Output;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_trigger = 2'b11;
    w_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_VReset) w_next = S_TRIG;
      end
      S_TRIG: begin
        w_trigger[r_sel] = 1'b0;
        if (r_trg == TRG_LAST) w_next = S_MEASURE;
      end
      S_MEASURE: begin
        // Input only matters on a tick; saturation ends the measurement too.
        if (r_tick && (!w_in || (r_cnt == CNT_MAX))) w_next = S_LATCH;
      end
      S_LATCH: begin
        if (!r_sel) begin
          w_next = S_TRIG;
        end else begin
          w_valid = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_sel  <= 1'b0;
      r_trg  <= '0;
      r_psc  <= '0;
      r_tick <= 1'b0;
      r_cnt  <= '0;
      r_to   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_VReset)  r_sel <= 1'b0;
      else if (r_state == S_LATCH && !r_sel) r_sel <= 1'b1;

      if (r_state == S_TRIG) r_trg <= r_trg + TRG_ONE;
      else                   r_trg <= '0;

      if (r_state == S_MEASURE) r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + PSC_ONE;
      else                      r_psc <= '0;

      // Registered so the first tick lands a full CLKS_PER_TICK after entry.
      r_tick <= (r_state == S_MEASURE) && (r_psc == PSC_LAST);

      if (r_state == S_TRIG) begin
        r_cnt <= '0;
      end else if (r_state == S_MEASURE && r_tick) begin
        if (w_in && (r_cnt < CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
        if (w_next == S_LATCH)         r_to  <= w_in;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_pos0    <= '0;
      r_pos1    <= '0;
      r_timeout <= 2'b00;
    end else if (r_state == S_LATCH) begin
      if (r_sel) r_pos1 <= w_new_pos;
      else       r_pos0 <= w_new_pos;
      r_timeout[r_sel] <= r_to;
    end
  end

  assign o_555_Trigger = w_trigger;
  assign o_Pos0        = r_pos0;
  assign o_Pos1        = r_pos1;
  assign o_Timeout     = r_timeout;
  assign o_Valid       = w_valid;
  assign o_Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_paddle_scan_ctrl.sv
// Directed bench for paddle_scan_ctrl with a cycle-level 555 paddle model.
module tb_paddle_scan_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst_N = 1'b1;
  logic       i_VReset = 1'b0;
  logic [1:0] i_555_Output = 2'b00;
  logic [1:0] o_555_Trigger;
  logic [7:0] o_Pos0;
  logic [7:0] o_Pos1;
  logic [1:0] o_Timeout;
  logic       o_Valid;
  logic       o_Busy;

  int n_vec = 0;
  int n_err = 0;
  int m_pos0 = 0;
  int m_pos1 = 0;

  paddle_scan_ctrl #(
    .CLKS_PER_TICK(4),
    .TRIG_CLKS    (2),
    .POS_W        (8),
    .MAX_TICKS    (20)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_N      (i_Rst_N),
    .i_VReset     (i_VReset),
    .i_555_Output (i_555_Output),
    .o_555_Trigger(o_555_Trigger),
    .o_Pos0       (o_Pos0),
    .o_Pos1       (o_Pos1),
    .o_Timeout    (o_Timeout),
    .o_Valid      (o_Valid),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int next_pos(input int old_pos, input int raw);
`ifdef PADDLE_AVG_EN
    return (old_pos + raw) / 2;
`else
    return raw;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    n_vec++;
    if (o_555_Trigger !== 2'b11 || o_Pos0 !== 8'd0 || o_Pos1 !== 8'd0 ||
        o_Timeout !== 2'b00 || o_Valid !== 1'b0 || o_Busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: trig=%b pos0=%0d pos1=%0d to=%b valid=%b busy=%b, need 11/0/0/00/0/0",
               tag, o_555_Trigger, o_Pos0, o_Pos1, o_Timeout, o_Valid, o_Busy);
    end
  endtask

  // Runs one frame starting from IDLE; the caller is #1 after a rising edge.
  // h0/h1: cycle (from each trigger start) at which the raw paddle output falls.
  task automatic run_scan(input string tag, input int h0, input int h1,
                          input int e0, input int e1, input logic [1:0] eto,
                          input int vr_mid, input bit vr_on_valid, input bit abort);
    int  h[2];
    int  cyc[2];
    bit  act[2];
    bit  prev_lo[2];
    int  lo_cnt[2];
    int  nvalid;
    int  post;
    bit  seen;
    int  x0;
    int  x1;
    h[0] = h0; h[1] = h1;
    for (int n = 0; n < 2; n++) begin
      cyc[n] = 0; act[n] = 1'b0; prev_lo[n] = 1'b0; lo_cnt[n] = 0;
    end
    nvalid = 0; post = 0; seen = 1'b0;
    x0 = next_pos(m_pos0, e0);
    x1 = next_pos(m_pos1, e1);

    i_VReset = 1'b1;
    @(posedge i_Clk); #1;
    i_VReset = 1'b0;
    n_vec++;
    if (o_Busy !== 1'b1 || o_555_Trigger !== 2'b10) begin
      n_err++;
      $display("FAIL %s start: busy=%b trig=%b, need 1/10", tag, o_Busy, o_555_Trigger);
    end

    for (int c = 1; c < 1000 && post < 3; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (o_555_Trigger[n] == 1'b0) begin
          lo_cnt[n]++;
          if (!prev_lo[n]) begin act[n] = 1'b1; cyc[n] = 0; end
          prev_lo[n] = 1'b1;
        end else begin
          prev_lo[n] = 1'b0;
        end
      end
      n_vec++;
      if (o_555_Trigger == 2'b00) begin
        n_err++;
        $display("FAIL %s both triggers low at cycle %0d", tag, c);
      end
      if (abort && o_555_Trigger[1] == 1'b0) begin
        #2 i_Rst_N = 1'b0;
        #1 check_reset_values({tag, " async"});
        m_pos0 = 0; m_pos1 = 0;
        i_555_Output = 2'b00;
        @(negedge i_Clk);
        i_Rst_N = 1'b1;
        @(posedge i_Clk); #1;
        return;
      end
      for (int n = 0; n < 2; n++) begin
        i_555_Output[n] = act[n] && (cyc[n] < h[n]);
        if (act[n]) cyc[n]++;
      end
      i_VReset = (c == vr_mid) || (vr_on_valid && o_Valid);
      if (o_Valid) begin
        nvalid++;
        seen = 1'b1;
      end else if (seen) begin
        if (post == 0) begin
          n_vec++;
          if (o_Pos0 !== 8'(x0) || o_Pos1 !== 8'(x1) || o_Timeout !== eto) begin
            n_err++;
            $display("FAIL %s result: pos0=%0d pos1=%0d to=%b, need %0d/%0d/%b",
                     tag, o_Pos0, o_Pos1, o_Timeout, x0, x1, eto);
          end
        end
        n_vec++;
        if (o_Busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s idle after valid: busy=%b, need 0", tag, o_Busy);
        end
        post++;
      end
      @(posedge i_Clk); #1;
    end
    i_VReset = 1'b0;

    n_vec++;
    if (nvalid != 1) begin
      n_err++;
      $display("FAIL %s valid pulses: got %0d, need 1", tag, nvalid);
    end
    n_vec++;
    if (lo_cnt[0] != 2 || lo_cnt[1] != 2) begin
      n_err++;
      $display("FAIL %s trigger widths: got %0d/%0d, need 2/2", tag, lo_cnt[0], lo_cnt[1]);
    end
    m_pos0 = x0;
    m_pos1 = x1;
  endtask

  task automatic test_reset;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #2;
    i_Rst_N = 1'b0;
    #1 check_reset_values("reset");
    @(posedge i_Clk); #1;
    check_reset_values("reset held");
    @(negedge i_Clk);
    i_Rst_N = 1'b1;
    @(posedge i_Clk); #1;
    check_reset_values("reset released");
    m_pos0 = 0; m_pos1 = 0;
  endtask

  task automatic test_basic;
    run_scan("basic", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    run_scan("timeout", 42, 100000, 10, 20, 2'b10, -1, 1'b0, 1'b0);
    run_scan("timeout clear", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b0);
  endtask

  task automatic test_vreset_ignored;
    run_scan("vreset busy", 42, 22, 10, 5, 2'b00, 20, 1'b1, 1'b0);
    run_scan("vreset idle", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    run_scan("mid reset", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b1);
    run_scan("after reset", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b0);
  endtask

  task automatic test_avg;
    test_reset();
    run_scan("avg scan1", 42, 22, 10, 5, 2'b00, -1, 1'b0, 1'b0);
    run_scan("avg scan2", 82, 22, 20, 5, 2'b00, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_vreset_ignored();
    test_reset_mid();
    test_avg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
